// File: rtl/inst_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: memory-controller burst side,
// redirect input and the decode-facing instruction stream.
interface inst_fetch_unit_if;
    logic        rdy_in;
    logic        mem_available_in;
    logic        mem_enable_out;
    logic [31:0] mem_addr_out;
    logic        mem_reset_out;
    logic        mem_word_done_in;
    logic [31:0] mem_inst_in;
    logic        mem_end_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_ready_in;

    modport master (
        input  rdy_in, mem_available_in, mem_word_done_in, mem_inst_in, mem_end_in,
        input  redirect_in, redirect_pc_in, inst_ready_in,
        output mem_enable_out, mem_addr_out, mem_reset_out,
        output inst_valid_out, inst_out, pc_out
    );

    modport slave (
        output rdy_in, mem_available_in, mem_word_done_in, mem_inst_in, mem_end_in,
        output redirect_in, redirect_pc_in, inst_ready_in,
        input  mem_enable_out, mem_addr_out, mem_reset_out,
        input  inst_valid_out, inst_out, pc_out
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: one line buffer filled by a line-aligned burst, words streamed
// to decode as they land; redirects restart fetch and abort bursts for other lines.
module inst_fetch_unit #(
    parameter int unsigned LINE_INSTS = 16,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    inst_fetch_unit_if.master bus
);
    localparam int unsigned      IDX_W    = $clog2(LINE_INSTS);
    localparam int unsigned      OFF_W    = IDX_W + 2;
    localparam logic [31:0]      OFF_MASK = 32'(LINE_INSTS * 4 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_INSTS - 1);

    typedef enum logic [1:0] { IDLE, REQ, FILL, DRAIN } state_t;

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & ~OFF_MASK;
    endfunction

    state_t                state, state_nxt;
    logic [31:0]           pc, pc_nxt;
    logic [31:0]           tag, tag_nxt;
    logic [LINE_INSTS-1:0] valid, valid_nxt;
    logic [IDX_W-1:0]      k, k_nxt;
    logic                  mem_enable, mem_enable_nxt;
    logic [31:0]           mem_addr, mem_addr_nxt;
    logic                  mem_reset, mem_reset_nxt;
    logic                  buf_we;
    logic [31:0]           line_buf [LINE_INSTS];

    logic                  vld_p1, vld_p1_nxt;
    logic [31:0]           inst_p1, inst_p1_nxt;
    logic [31:0]           pc_p1, pc_p1_nxt;

    logic                  advance, la_hit;
    logic [31:0]           la, la_base, redir_pc, redir_base;
    logic [IDX_W-1:0]      la_idx;

    // Lookup address: the word after the current one when decode takes it this cycle.
    always_comb begin
        advance    = vld_p1 && bus.inst_ready_in;
        la         = advance ? pc + 32'd4 : pc;
        la_base    = line_base(la);
        la_idx     = la[OFF_W-1:2];
        la_hit     = (la_base == tag) && valid[la_idx];
        redir_pc   = bus.redirect_pc_in & ~32'd3;
        redir_base = line_base(redir_pc);
    end

    // Output stage p1: registered word/pc presented to decode.
    always_comb begin
        pc_nxt      = pc;
        vld_p1_nxt  = vld_p1;
        inst_p1_nxt = inst_p1;
        pc_p1_nxt   = pc_p1;
        if (bus.redirect_in) begin
            pc_nxt     = redir_pc;
            vld_p1_nxt = 1'b0;
        end else if (!(vld_p1 && !bus.inst_ready_in)) begin
            pc_nxt     = la;
            vld_p1_nxt = la_hit;
            if (la_hit) begin
                inst_p1_nxt = line_buf[la_idx];
                pc_p1_nxt   = la;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        tag_nxt        = tag;
        valid_nxt      = valid;
        k_nxt          = k;
        mem_enable_nxt = mem_enable;
        mem_addr_nxt   = mem_addr;
        mem_reset_nxt  = 1'b0;
        buf_we         = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.redirect_in && !la_hit) begin
                    state_nxt = REQ;
                    valid_nxt = '0;
                    tag_nxt   = la_base;
                end
            end
            REQ: begin
                // A redirect before the burst starts just retargets the pending request.
                if (bus.redirect_in && redir_base != tag) begin
                    tag_nxt = redir_base;
                end else if (bus.mem_available_in) begin
                    mem_enable_nxt = 1'b1;
                    mem_addr_nxt   = tag;
                    k_nxt          = '0;
                    state_nxt      = FILL;
                end
            end
            FILL: begin
                if (bus.redirect_in && redir_base != tag) begin
                    mem_enable_nxt = 1'b0;
                    mem_reset_nxt  = 1'b1;
                    valid_nxt      = '0;
                    state_nxt      = DRAIN;
                end else begin
                    if (bus.mem_word_done_in) begin
                        buf_we       = 1'b1;
                        valid_nxt[k] = 1'b1;
                        k_nxt        = k + IDX_W'(1);
                    end
                    if ((bus.mem_word_done_in && k == LAST_IDX) || bus.mem_end_in) begin
                        mem_enable_nxt = 1'b0;
                        state_nxt      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.mem_available_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            tag        <= '0;
            valid      <= '0;
            k          <= '0;
            mem_enable <= 1'b0;
            mem_addr   <= '0;
            mem_reset  <= 1'b0;
            vld_p1     <= 1'b0;
            inst_p1    <= '0;
            pc_p1      <= '0;
        end else if (bus.rdy_in) begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            tag        <= tag_nxt;
            valid      <= valid_nxt;
            k          <= k_nxt;
            mem_enable <= mem_enable_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_reset  <= mem_reset_nxt;
            vld_p1     <= vld_p1_nxt;
            inst_p1    <= inst_p1_nxt;
            pc_p1      <= pc_p1_nxt;
        end
    end

    // Line storage carries no reset; the valid bits qualify every entry.
    always_ff @(posedge clk_in) begin
        if (bus.rdy_in && buf_we) line_buf[k] <= bus.mem_inst_in;
    end

    assign bus.mem_enable_out = mem_enable;
    assign bus.mem_addr_out   = mem_addr;
    assign bus.mem_reset_out  = mem_reset;
    assign bus.inst_valid_out = vld_p1;
    assign bus.inst_out       = inst_p1;
    assign bus.pc_out         = pc_p1;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a one-word-per-cycle burst memory model
// returning 0x1000 + address for every word.
module tb_inst_fetch_unit;
    localparam int LINE = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.LINE_INSTS(LINE), .RESET_PC(32'h0)) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc, cnt, n_acc, n_rise, n_rst, first_cyc;
    bit          burst;
    logic        prev_en;
    logic [31:0] mbase;
    logic [31:0] acc_pc   [32];
    logic [31:0] acc_inst [32];
    int          acc_cyc  [32];
    logic [31:0] rise_addr[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model decides this cycle's inputs from the outputs, then one clock passes.
    task automatic cycle();
        if (rst_n && bus.rdy_in) begin
            bus.mem_word_done_in = 1'b0;
            bus.mem_end_in       = 1'b0;
            if (!bus.mem_enable_out) begin
                burst = 1'b0;
            end else if (!burst) begin
                burst = 1'b1;
                mbase = bus.mem_addr_out;
                cnt   = 0;
            end
            if (burst && cnt < LINE) begin
                bus.mem_word_done_in = 1'b1;
                bus.mem_inst_in      = 32'h1000 + mbase + 32'(4 * cnt);
                cnt++;
                bus.mem_end_in = (cnt == LINE);
            end
            bus.mem_available_in = !burst;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        bus.rdy_in           = 1'b1;
        bus.inst_ready_in    = 1'b0;
        bus.redirect_in      = 1'b0;
        bus.redirect_pc_in   = 32'h0;
        bus.mem_word_done_in = 1'b0;
        bus.mem_inst_in      = 32'h0;
        bus.mem_end_in       = 1'b0;
        bus.mem_available_in = 1'b0;
        burst = 1'b0;
        cnt   = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_enable", bus.mem_enable_out, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.inst_valid_out, 32'h0);
        chk("rst_addr",  bus.mem_addr_out,   32'h0);
        chk("rst_abort", bus.mem_reset_out,  32'h0);
        chk("rst_inst",  bus.inst_out,       32'h0);
        chk("rst_pc",    bus.pc_out,         32'h0);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #2;
        // Sequential stream of line 0, then fall-through into line 0x40.
        do_reset();
        bus.inst_ready_in = 1'b1;
        n_acc = 0; n_rise = 0; prev_en = 1'b0; first_cyc = -1;
        for (int i = 0; i < 80 && n_acc < 17; i++) begin
            cycle();
            if (bus.mem_enable_out && !prev_en && n_rise < 4) begin
                rise_addr[n_rise] = bus.mem_addr_out;
                n_rise++;
            end
            prev_en = bus.mem_enable_out;
            if (bus.inst_valid_out) begin
                if (n_acc == 0) first_cyc = cyc;
                acc_pc[n_acc]   = bus.pc_out;
                acc_inst[n_acc] = bus.inst_out;
                acc_cyc[n_acc]  = cyc;
                n_acc++;
            end
        end
        chk("t1_words", n_acc, 17);
        chk("t1_first_latency", first_cyc, 4);
        chk("t1_burst0_addr", rise_addr[0], 32'h0);
        chk("t1_burst1_addr", rise_addr[1], 32'h40);
        for (int i = 0; i < 17 && i < n_acc; i++) begin
            chk($sformatf("t1_pc%0d", i), acc_pc[i], 32'(4 * i));
            chk($sformatf("t1_inst%0d", i), acc_inst[i], 32'h1000 + 32'(4 * i));
        end
        chk("t1_last_word_cycle", acc_cyc[15], 19);
        chk("t5_fallthrough_cycle", acc_cyc[16], 23);

        // Decode stall at pc 0x8.
        do_reset();
        bus.inst_ready_in = 1'b1;
        for (int i = 0; i < 40 && !(bus.inst_valid_out && bus.pc_out == 32'h8); i++) cycle();
        chk("t2_reach_8", bus.pc_out, 32'h8);
        bus.inst_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_stall_valid", bus.inst_valid_out, 32'h1);
            chk("t2_stall_pc", bus.pc_out, 32'h8);
            chk("t2_stall_inst", bus.inst_out, 32'h1008);
        end
        bus.inst_ready_in = 1'b1;
        cycle();
        chk("t2_resume_pc", bus.pc_out, 32'hC);
        chk("t2_resume_inst", bus.inst_out, 32'h100C);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            chk("t2_stream_pc", bus.pc_out, 32'hC + 32'(4 * i));
        end
        chk("t2_stream_valid", bus.inst_valid_out, 32'h1);
        chk("t2_fill_done_enable", bus.mem_enable_out, 32'h0);
        chk("t2_fill_words", cnt, LINE);

        // Redirect to another line aborts the fill.
        do_reset();
        bus.inst_ready_in = 1'b1;
        for (int i = 0; i < 50 && cnt < 3; i++) cycle();
        chk("t3_fill_started", cnt, 3);
        bus.redirect_in    = 1'b1;
        bus.redirect_pc_in = 32'h44;
        cycle();
        bus.redirect_in = 1'b0;
        chk("t3_abort_pulse", bus.mem_reset_out, 32'h1);
        chk("t3_enable_drop", bus.mem_enable_out, 32'h0);
        chk("t3_valid_flush", bus.inst_valid_out, 32'h0);
        n_rst = 0; n_rise = 0; prev_en = 1'b0;
        for (int i = 0; i < 50 && !bus.inst_valid_out; i++) begin
            cycle();
            if (bus.mem_reset_out) n_rst++;
            if (bus.mem_enable_out && !prev_en && n_rise < 4) begin
                rise_addr[n_rise] = bus.mem_addr_out;
                n_rise++;
            end
            prev_en = bus.mem_enable_out;
        end
        chk("t3_single_pulse", n_rst, 0);
        chk("t3_new_bursts", n_rise, 1);
        chk("t3_burst_addr", rise_addr[0], 32'h40);
        chk("t3_first_valid", bus.inst_valid_out, 32'h1);
        chk("t3_first_pc", bus.pc_out, 32'h44);
        chk("t3_first_inst", bus.inst_out, 32'h1044);

        // Redirect within the line being filled: no abort; low pc bits ignored.
        do_reset();
        for (int i = 0; i < 50 && cnt < 5; i++) cycle();
        chk("t4_k5", cnt, 5);
        bus.redirect_in    = 1'b1;
        bus.redirect_pc_in = 32'h32;
        cycle();
        bus.redirect_in = 1'b0;
        chk("t4_no_abort", bus.mem_reset_out, 32'h0);
        chk("t4_enable_held", bus.mem_enable_out, 32'h1);
        chk("t4_valid_flush", bus.inst_valid_out, 32'h0);
        bus.inst_ready_in = 1'b1;
        n_rst = 0;
        for (int i = 0; i < 50 && !bus.inst_valid_out; i++) begin
            cycle();
            if (bus.mem_reset_out) n_rst++;
        end
        chk("t4_no_abort_later", n_rst, 0);
        chk("t4_pc", bus.pc_out, 32'h30);
        chk("t4_inst", bus.inst_out, 32'h1030);
        chk("t4_pulses_seen", cnt, 14);
        cycle();
        chk("t4_next_pc", bus.pc_out, 32'h34);
        chk("t4_next_inst", bus.inst_out, 32'h1034);

        // Global freeze mid-fill with the controller frozen too.
        do_reset();
        bus.inst_ready_in = 1'b1;
        for (int i = 0; i < 50 && cnt < 6; i++) cycle();
        chk("t6_pre_pc", bus.pc_out, 32'h10);
        bus.rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t6_frz_valid", bus.inst_valid_out, 32'h1);
            chk("t6_frz_pc", bus.pc_out, 32'h10);
            chk("t6_frz_inst", bus.inst_out, 32'h1010);
            chk("t6_frz_enable", bus.mem_enable_out, 32'h1);
        end
        bus.rdy_in = 1'b1;
        cycle();
        chk("t6_resume_pc", bus.pc_out, 32'h14);
        chk("t6_resume_inst", bus.inst_out, 32'h1014);
        for (int i = 1; i <= 10; i++) begin
            cycle();
            chk("t6_stream_pc", bus.pc_out, 32'h14 + 32'(4 * i));
            chk("t6_stream_inst", bus.inst_out, 32'h1014 + 32'(4 * i));
        end

        // Reset asserted mid-burst: enable drops at once, fetch restarts from RESET_PC.
        do_reset();
        for (int i = 0; i < 50 && cnt < 2; i++) cycle();
        chk("t7_mid_burst", bus.mem_enable_out, 32'h1);
        do_reset();
        cycle();
        cycle();
        chk("t7_restart_enable", bus.mem_enable_out, 32'h1);
        chk("t7_restart_addr", bus.mem_addr_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
